// File: rtl/alu_bist_ctrl_pkg.sv
// Shared definitions for the arithmetic-unit BIST controller: opcodes,
// controller states and the LFSR polynomial/seed helpers.
package alu_bist_ctrl_pkg;

    localparam int OP_ADD = 0;
    localparam int OP_OR  = 1;
    localparam int OP_SUB = 2;
    localparam int OP_XOR = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } bistState_t;

    // Taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One left shift of the Fibonacci LFSR; feedback enters at bit 0
    function automatic logic [15:0] lfsrNext(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

    // An all-zero seed would lock the LFSR, so it is swapped for the default
    function automatic logic [15:0] safeSeed(input logic [15:0] s);
        return (s == 16'd0) ? DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/alu_bist_ctrl_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and step enable.
module bist_lfsr16
    import alu_bist_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    // Load has priority over step so a restart always begins at the seed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_SEED;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= lfsrNext(q);
        end
    end

endmodule

// File: rtl/alu_bist_ctrl.sv
// BIST controller: drives LFSR operands into an N-bit arithmetic unit,
// checks each result against a built-in reference and tallies mismatches.
module alu_bist_ctrl
    import alu_bist_ctrl_pkg::*;
#(
    parameter int          N       = 4,
    parameter int          OPCODE  = 2,
    parameter int          NUM_VEC = 100,
    parameter int          SETTLE  = 1,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] op_a,
    output logic [N-1:0] op_b,
    input  logic [N-1:0] dut_out,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [15:0]  fail_count,
    output logic [15:0]  vec_count,
    output logic [15:0]  first_fail_idx
);

    localparam logic [15:0] RUN_SEED    = safeSeed(SEED);
    localparam int          SETTLE_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
    localparam logic [15:0] LAST_COUNT  = 16'(NUM_VEC);

    bistState_t           r_state;
    bistState_t           w_nextState;
    logic [SETTLE_W-1:0]  r_settle;
    logic [15:0]          r_vecCount;
    logic [15:0]          r_failCount;
    logic [15:0]          r_firstFailIdx;
    logic [15:0]          w_lfsrQ;
    logic [N-1:0]         w_expected;
    logic                 w_start;
    logic                 w_sample;
    logic                 w_lastVec;
    logic                 w_mismatch;
    logic                 w_unusedLfsr;

    // start is honoured from IDLE or DONE, never in the middle of a run
    assign w_start    = start && (r_state != ST_DRIVE);
    assign w_sample   = (r_state == ST_DRIVE) && (r_settle == SETTLE_LAST);
    assign w_lastVec  = w_sample && ((r_vecCount + 16'd1) == LAST_COUNT);
    assign w_mismatch = (dut_out != w_expected);

    // The final vector does not step the LFSR so the operands hold in DONE
    bist_lfsr16 #(
        .RESET_SEED (RUN_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (w_start),
        .seed (RUN_SEED),
        .step (w_sample && !w_lastVec),
        .q    (w_lfsrQ)
    );

    assign w_unusedLfsr = ^w_lfsrQ;

    assign op_a = (r_state == ST_IDLE) ? '0 : w_lfsrQ[N-1:0];
    assign op_b = (r_state == ST_IDLE) ? '0 : w_lfsrQ[2*N-1:N];

    // Reference result for the configured operation, wrapping to N bits
    always_comb begin
        w_expected = '0;
        case (OPCODE)
            OP_ADD:  w_expected = op_a + op_b;
            OP_OR:   w_expected = op_a | op_b;
            OP_SUB:  w_expected = op_a - op_b;
            OP_XOR:  w_expected = op_a ^ op_b;
            default: w_expected = '0;
        endcase
    end

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state selection: start launches a run, the last sample ends it
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (w_start)   w_nextState = ST_DRIVE;
            ST_DRIVE: if (w_lastVec) w_nextState = ST_DONE;
            ST_DONE:  if (w_start)   w_nextState = ST_DRIVE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // Settle timer and result counters, cleared at every start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle       <= '0;
            r_vecCount     <= 16'd0;
            r_failCount    <= 16'd0;
            r_firstFailIdx <= 16'hFFFF;
        end else if (w_start) begin
            r_settle       <= '0;
            r_vecCount     <= 16'd0;
            r_failCount    <= 16'd0;
            r_firstFailIdx <= 16'hFFFF;
        end else if (w_sample) begin
            r_settle   <= '0;
            r_vecCount <= r_vecCount + 16'd1;
            if (w_mismatch) begin
                r_failCount <= r_failCount + 16'd1;
                if (r_firstFailIdx == 16'hFFFF) begin
                    r_firstFailIdx <= r_vecCount;
                end
            end
        end else if (r_state == ST_DRIVE) begin
            r_settle <= r_settle + 1'b1;
        end
    end

    assign busy           = (r_state == ST_DRIVE);
    assign done           = (r_state == ST_DONE);
    assign pass           = (r_state == ST_DONE) && (r_failCount == 16'd0);
    assign fail_count     = r_failCount;
    assign vec_count      = r_vecCount;
    assign first_fail_idx = r_firstFailIdx;

endmodule
